uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter PARITY_EN, default 0; when 1, an even-parity bit is inserted after the data bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have ports req0_valid  input  1  and  req0_data  input  8: requester 0 byte offer.
REQ-006 SHALL have port req0_ready  output  1  requester 0 accept strobe.
REQ-007 SHALL have ports req1_valid  input  1,  req1_data  input  8,  req1_ready  output  1: the same for requester 1.
REQ-008 SHALL have port tx  output  1  registered serial line; idle high.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port grant_id  output  1  index of the most recently accepted requester.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL run a baud counter 0..CLKS_PER_BIT-1, cleared on handshake; bit_end = (counter == CLKS_PER_BIT-1).
REQ-013 SHALL assert reqN_ready combinationally only in IDLE, only for the granted requester, and only while its valid is high; it is never high in both requesters in the same cycle.
REQ-014 SHALL arbitrate in IDLE: one valid -> that requester wins; both valid -> the requester not in grant_id wins (round-robin).
REQ-015 SHALL complete a handshake on the edge where valid && ready, latching the winning data byte and updating grant_id.
REQ-016 SHALL go IDLE -> START on handshake; tx becomes 0 at that same edge.
REQ-017 SHALL hold each bit for exactly CLKS_PER_BIT cycles; START -> DATA on bit_end.
REQ-018 SHALL shift data LSB first; a 3-bit index advances on bit_end; DATA -> PARITY (PARITY_EN=1) or STOP after bit 7.
REQ-019 SHALL drive tx in PARITY with the XOR of the 8 latched bits (even parity); PARITY -> STOP on bit_end.
REQ-020 SHALL drive tx=1 in STOP; STOP -> IDLE on bit_end; IDLE lasts at least 1 cycle before the next handshake.
REQ-021 SHALL ignore valid and data changes while busy; offers are not queued.
REQ-022 SHALL produce a minimum handshake-to-handshake spacing of (10+PARITY_EN)*CLKS_PER_BIT + 1 cycles.
REQ-023 SHALL leave grant_id unchanged when no handshake occurs.

Reset
REQ-024 SHALL, on any edge with rst_n=0, enter IDLE with tx=1, busy=0, grant_id=1 (requester 0 wins the first contention), counter=0, bit index=0, latched byte=0.
REQ-025 SHALL, when reset occurs mid-frame, abandon the frame, set tx=1 on that edge, and suppress any ready during reset.
REQ-026 SHALL hold both ready outputs low while rst_n=0, regardless of valid.

Verification
REQ-027 SHALL be tested with CLKS_PER_BIT=4, PARITY_EN=0 and req0 sending 0xA5: tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles; busy high for 40 cycles.
REQ-028 SHALL be tested with PARITY_EN=1 sending 0x07: the parity bit is 1; sending 0x03: the parity bit is 0; frame lasts 44 cycles.
REQ-029 SHALL be tested with both valids held high out of reset: accepted order is req0, req1, req0, and grant_id reads 0, 1, 0.
REQ-030 SHALL be tested with req1_data changed mid-frame: the transmitted byte equals the value at handshake.
REQ-031 SHALL be tested with rst_n pulsed low during DATA bit 3: tx=1 and busy=0 after that edge, no ready is asserted, and the next frame starts cleanly with its start bit.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Two-requester UART transmitter: round-robin arbitration in IDLE, then one
// 8N1 frame (optional even parity) per accepted byte, LSB first.
module uart_tx_sched #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam bit PAR_ON = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             tx_q, tx_d;
    logic             grant_q, grant_d;
    logic             bit_end;
    logic             win;
    logic             hs;

    assign bit_end  = (cnt_q == CNT_MAX);
    assign tx       = tx_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

    // Arbitration: lone valid wins; on contention the requester not last granted wins.
    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid) begin
            win = ~grant_q;
        end else begin
            win = req1_valid;
        end
        req0_ready = rst_n && (state_q == IDLE) && req0_valid && !win;
        req1_ready = rst_n && (state_q == IDLE) && req1_valid && win;
        hs         = req0_ready || req1_ready;
    end

    // Frame sequencing: next state, baud counter, bit index and serial bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        tx_d    = tx_q;
        grant_d = grant_q;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                idx_d = 3'd0;
                if (hs) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    data_d  = win ? req1_data : req0_data;
                    grant_d = win;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        if (PAR_ON) begin
                            state_d = PARITY;
                            tx_d    = ^data_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            tx_q    <= 1'b1;
            grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench: instance a (4 clk/bit, no parity), instance b (4 clk/bit, even parity).
module tb_uart_tx_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_v0, a_v1, b_v0, b_v1;
    logic [7:0] a_d0, a_d1, b_d0, b_d1;
    logic       a_r0, a_r1, a_tx, a_busy, a_gid;
    logic       b_r0, b_r1, b_tx, b_busy, b_gid;

    int  n_tests = 0;
    int  n_fail  = 0;
    logic samp  [0:63];
    logic bsamp [0:63];
    time hs_time;

    uart_tx_sched #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
        .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
        .tx(a_tx), .busy(a_busy), .grant_id(a_gid)
    );

    uart_tx_sched #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
        .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
        .tx(b_tx), .busy(b_busy), .grant_id(b_gid)
    );

    // Wait (bounded) for a ready strobe, then return on the handshake edge.
    task automatic wait_hs(input bit sel, output int who, output bit ok, output bit both);
        ok = 1'b0; who = -1; both = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (!sel) begin
                if (a_r0 && a_r1) both = 1'b1;
                if (a_r0 || a_r1) begin who = a_r1 ? 1 : 0; ok = 1'b1; end
            end else begin
                if (b_r0 && b_r1) both = 1'b1;
                if (b_r0 || b_r1) begin who = b_r1 ? 1 : 0; ok = 1'b1; end
            end
        end
        if (ok) begin
            @(posedge clk);
            hs_time = $time;
        end
    endtask

    // Record tx/busy once per cycle after a handshake; drop valids, optionally mutate req1 data.
    task automatic capture(input bit sel, input int ncyc, input int mut_at, input logic [7:0] mut_val);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            samp[i]  = sel ? b_tx : a_tx;
            bsamp[i] = sel ? b_busy : a_busy;
            if (i == 0) begin a_v0 = 1'b0; a_v1 = 1'b0; b_v0 = 1'b0; b_v1 = 1'b0; end
            if (i == mut_at) a_d1 = mut_val;
        end
    endtask

    function automatic logic [7:0] decode();
        logic [7:0] d;
        for (int k = 0; k < 8; k++) d[k] = samp[4*(k+1)+1];
        return d;
    endfunction

    function automatic logic [3:0] grp(input int base);
        return {samp[base], samp[base+1], samp[base+2], samp[base+3]};
    endfunction

    function automatic int busy_count(input int ncyc);
        int c = 0;
        for (int i = 0; i < ncyc; i++) if (bsamp[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a_v0 = 1'b0; a_v1 = 1'b0; b_v0 = 1'b0; b_v1 = 1'b0;
        a_d0 = 8'h00; a_d1 = 8'h00; b_d0 = 8'h00; b_d1 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a_v0 = 1'b1; a_v1 = 1'b1; b_v0 = 1'b1; b_v1 = 1'b1;
        #1;
        n_tests++;
        if ({a_r0, a_r1, b_r0, b_r1} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0000", {a_r0, a_r1, b_r0, b_r1});
        end
        n_tests++;
        if ({a_tx, a_busy, a_gid} !== 3'b101) begin
            n_fail++; $display("FAIL reset_a_state tx/busy/gid: got %b expected 101", {a_tx, a_busy, a_gid});
        end
        n_tests++;
        if ({b_tx, b_busy, b_gid} !== 3'b101) begin
            n_fail++; $display("FAIL reset_b_state tx/busy/gid: got %b expected 101", {b_tx, b_busy, b_gid});
        end
        a_v0 = 1'b0; a_v1 = 1'b0; b_v0 = 1'b0; b_v1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_frame_a5();
        int who; bit ok, both;
        logic [9:0] exp_bits;
        exp_bits = {1'b1, 8'hA5, 1'b0};
        @(posedge clk); #1;
        a_d0 = 8'hA5; a_v0 = 1'b1;
        wait_hs(1'b0, who, ok, both);
        n_tests++;
        if (!ok || who !== 0) begin
            n_fail++; $display("FAIL a5_handshake: ok=%0d who=%0d expected ok=1 who=0", ok, who);
        end
        capture(1'b0, 44, -1, 8'h00);
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (grp(4*k) !== {4{exp_bits[k]}}) begin
                n_fail++; $display("FAIL a5_bit%0d: got %b expected %b", k, grp(4*k), {4{exp_bits[k]}});
            end
        end
        n_tests++;
        if (busy_count(44) !== 40 || grp(40) !== 4'b1111) begin
            n_fail++; $display("FAIL a5_busy_idle: busy=%0d idle_tx=%b expected 40 1111", busy_count(44), grp(40));
        end
        n_tests++;
        if (a_gid !== 1'b0) begin
            n_fail++; $display("FAIL a5_grant: got %b expected 0", a_gid);
        end
    endtask

    task automatic test_parity();
        int who; bit ok, both;
        logic [7:0] vals [0:1];
        logic       pars [0:1];
        vals[0] = 8'h07; pars[0] = 1'b1;
        vals[1] = 8'h03; pars[1] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(posedge clk); #1;
            b_d0 = vals[n]; b_v0 = 1'b1;
            wait_hs(1'b1, who, ok, both);
            capture(1'b1, 48, -1, 8'h00);
            n_tests++;
            if (!ok || grp(0) !== 4'b0000 || decode() !== vals[n]) begin
                n_fail++; $display("FAIL parity_data%0d: ok=%0d start=%b byte=%h expected start=0000 byte=%h",
                                   n, ok, grp(0), decode(), vals[n]);
            end
            n_tests++;
            if (grp(36) !== {4{pars[n]}}) begin
                n_fail++; $display("FAIL parity_bit%0d: got %b expected %b", n, grp(36), {4{pars[n]}});
            end
            n_tests++;
            if (grp(40) !== 4'b1111 || busy_count(48) !== 44) begin
                n_fail++; $display("FAIL parity_len%0d: stop=%b busy=%0d expected 1111 44", n, grp(40), busy_count(48));
            end
        end
    endtask

    task automatic test_round_robin();
        int who; bit ok, both;
        int  exp_who [0:2];
        time t_prev;
        exp_who[0] = 0; exp_who[1] = 1; exp_who[2] = 0;
        t_prev = 0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        a_d0 = 8'h11; a_d1 = 8'h22; a_v0 = 1'b1; a_v1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wait_hs(1'b0, who, ok, both);
            n_tests++;
            if (!ok || both || who !== exp_who[n]) begin
                n_fail++; $display("FAIL rr_order%0d: ok=%0d both=%0d who=%0d expected who=%0d", n, ok, both, who, exp_who[n]);
            end
            @(negedge clk);
            n_tests++;
            if (a_gid !== 1'(exp_who[n])) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b expected %0d", n, a_gid, exp_who[n]);
            end
            if (n > 0) begin
                n_tests++;
                if ((hs_time - t_prev) !== 410) begin
                    n_fail++; $display("FAIL rr_spacing%0d: got %0t expected 410", n, hs_time - t_prev);
                end
            end
            t_prev = hs_time;
        end
        a_v0 = 1'b0; a_v1 = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (!a_busy) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL rr_drain: busy still %b expected 0", a_busy);
        end
    endtask

    task automatic test_data_hold();
        int who; bit ok, both;
        @(posedge clk); #1;
        a_d1 = 8'h3C; a_v1 = 1'b1;
        wait_hs(1'b0, who, ok, both);
        capture(1'b0, 44, 10, 8'hFF);
        n_tests++;
        if (!ok || who !== 1 || decode() !== 8'h3C) begin
            n_fail++; $display("FAIL hold_byte: ok=%0d who=%0d byte=%h expected who=1 byte=3c", ok, who, decode());
        end
        n_tests++;
        if (a_gid !== 1'b1 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL hold_grant: gid=%b busy=%b expected 1 0", a_gid, a_busy);
        end
    endtask

    task automatic test_reset_mid();
        int who; bit ok, both;
        @(posedge clk); #1;
        a_d0 = 8'hF0; a_v0 = 1'b1;
        wait_hs(1'b0, who, ok, both);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 0) a_v0 = 1'b0;
        end
        n_tests++;
        if (a_tx !== 1'b0 || a_busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_bit3: tx=%b busy=%b expected 0 1", a_tx, a_busy);
        end
        rst_n = 1'b0; a_v0 = 1'b1; a_v1 = 1'b1;
        #1;
        n_tests++;
        if ({a_r0, a_r1} !== 2'b00) begin
            n_fail++; $display("FAIL mid_ready_in_reset: got %b expected 00", {a_r0, a_r1});
        end
        @(posedge clk); #1;
        n_tests++;
        if ({a_tx, a_busy, a_r0, a_r1, a_gid} !== 5'b10001) begin
            n_fail++; $display("FAIL mid_after_reset tx/busy/r0/r1/gid: got %b expected 10001",
                               {a_tx, a_busy, a_r0, a_r1, a_gid});
        end
        a_v1 = 1'b0;
        a_d0 = 8'h5A;
        rst_n = 1'b1;
        wait_hs(1'b0, who, ok, both);
        capture(1'b0, 44, -1, 8'h00);
        n_tests++;
        if (!ok || who !== 0 || grp(0) !== 4'b0000 || decode() !== 8'h5A || grp(36) !== 4'b1111 || busy_count(44) !== 40) begin
            n_fail++; $display("FAIL mid_next_frame: ok=%0d who=%0d start=%b byte=%h stop=%b busy=%0d expected 1 0 0000 5a 1111 40",
                               ok, who, grp(0), decode(), grp(36), busy_count(44));
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_parity();
        test_round_robin();
        test_data_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
